// File: rtl/mor1kx_dpram_ctrl_pkg.sv
// Shared types and constants for the dual-port RAM controller.
package mor1kx_dpram_ctrl_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam int unsigned DEFAULT_CLEAR_VALUE = 0;

endpackage

// File: rtl/mor1kx_dpram_ctrl_if.sv
// Request/grant bundle between the RAM controller and its clients.
interface mor1kx_dpram_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  clear_req_i;
  logic                  busy_o;
  logic                  wa_req_i;
  logic [ADDR_WIDTH-1:0] wa_addr_i;
  logic [DATA_WIDTH-1:0] wa_data_i;
  logic                  wa_gnt_o;
  logic                  wb_req_i;
  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  wb_gnt_o;
  logic                  rd_req_i;
  logic [ADDR_WIDTH-1:0] rd_addr_i;
  logic                  rd_gnt_o;
  logic                  rd_valid_o;
  logic [DATA_WIDTH-1:0] rd_data_o;

  modport master (
    output clear_req_i, wa_req_i, wa_addr_i, wa_data_i,
    output wb_req_i, wb_addr_i, wb_data_i, rd_req_i, rd_addr_i,
    input  busy_o, wa_gnt_o, wb_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  clear_req_i, wa_req_i, wa_addr_i, wa_data_i,
    input  wb_req_i, wb_addr_i, wb_data_i, rd_req_i, rd_addr_i,
    output busy_o, wa_gnt_o, wb_gnt_o, rd_gnt_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/mor1kx_simple_dpram_sclk.sv
// Single-clock simple dual-port RAM with registered read and optional write-first bypass.
module mor1kx_simple_dpram_sclk #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int ENABLE_BYPASS = 1
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
    if (re) begin
      if (ENABLE_BYPASS != 0 && we && waddr == raddr) dout <= din;
      else                                             dout <= mem[raddr];
    end
  end

endmodule

// File: rtl/mor1kx_dpram_ctrl.sv
// RAM controller: clear sweep after reset/on request, two arbitrated writers, one reader.
// Define MOR1KX_DPRAM_CTRL_ROUND_ROBIN_EN for alternating arbitration; default is A-first priority.
module mor1kx_dpram_ctrl
  import mor1kx_dpram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = DATA_WIDTH'(DEFAULT_CLEAR_VALUE)
) (
  input logic                clk,
  input logic                rst,
  mor1kx_dpram_ctrl_if.slave bus
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  rd_valid_p1;
  logic                  busy;
  logic                  sweep_we;
  logic                  gnt_a;
  logic                  gnt_b;
  logic                  rd_gnt;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
`ifdef MOR1KX_DPRAM_CTRL_ROUND_ROBIN_EN
  logic                  prio_b;
`endif

  // A clear request seen in RUN already blocks traffic in that same cycle.
  assign busy     = rst || state == CLEAR || bus.clear_req_i;
  assign sweep_we = state == CLEAR && !rst;
  assign rd_gnt   = bus.rd_req_i && !busy;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!busy) begin
`ifdef MOR1KX_DPRAM_CTRL_ROUND_ROBIN_EN
      if (bus.wa_req_i && bus.wb_req_i) begin
        gnt_a = !prio_b;
        gnt_b = prio_b;
      end else begin
        gnt_a = bus.wa_req_i;
        gnt_b = bus.wb_req_i;
      end
`else
      gnt_a = bus.wa_req_i;
      gnt_b = bus.wb_req_i && !bus.wa_req_i;
`endif
    end
  end

  assign ram_we    = sweep_we || gnt_a || gnt_b;
  assign ram_waddr = sweep_we ? sweep_addr  : (gnt_a ? bus.wa_addr_i : bus.wb_addr_i);
  assign ram_din   = sweep_we ? CLEAR_VALUE : (gnt_a ? bus.wa_data_i : bus.wb_data_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      sweep_addr  <= '0;
      rd_valid_p1 <= 1'b0;
`ifdef MOR1KX_DPRAM_CTRL_ROUND_ROBIN_EN
      prio_b      <= 1'b0;
`endif
    end else begin
      rd_valid_p1 <= rd_gnt;
`ifdef MOR1KX_DPRAM_CTRL_ROUND_ROBIN_EN
      if (gnt_a)      prio_b <= 1'b1;
      else if (gnt_b) prio_b <= 1'b0;
`endif
      case (state)
        CLEAR: begin
          sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
          if (sweep_addr == {ADDR_WIDTH{1'b1}}) state <= RUN;
        end
        RUN: begin
          if (bus.clear_req_i) begin
            state      <= CLEAR;
            sweep_addr <= '0;
          end
        end
      endcase
    end
  end

  mor1kx_simple_dpram_sclk #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .ENABLE_BYPASS(1)
  ) u_ram (
    .clk  (clk),
    .raddr(bus.rd_addr_i),
    .re   (rd_gnt),
    .waddr(ram_waddr),
    .we   (ram_we),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // A reset cycle must not expose a response that was in flight.
  assign bus.busy_o     = busy;
  assign bus.wa_gnt_o   = gnt_a;
  assign bus.wb_gnt_o   = gnt_b;
  assign bus.rd_gnt_o   = rd_gnt;
  assign bus.rd_valid_o = rd_valid_p1 && !rst;
  assign bus.rd_data_o  = ram_dout;

endmodule
